// File: rtl/uart_byte_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
//   Receive-side UART deserializer. It turns the asynchronous serial line
//   (8N1, LSB first, idle high) into parallel bytes. Each good byte is
//   presented with a one-cycle rx_valid strobe. The line is sampled at mid-bit
//   using a baud counter that runs on sys_clk.
//
//   Optional build macro: UART_RX_PARITY_EN
//     defined   : 8E1 frame. A PARITY state sits between DATA and STOP. A
//                 parity mismatch turns an otherwise good frame into a
//                 frame_err pulse.
//     undefined : 8N1 frame. The bit after data bit 7 is the stop bit.
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   BAUD_RATE  serial bit rate in bit/s (CLK_FREQ/BAUD_RATE must be >= 4)
//
// Ports
//   sys_clk    in   system clock; all logic runs on its rising edge
//   sys_rst    in   synchronous, active-high reset
//   uart_rx    in   asynchronous serial input, idle high
//   rx_data    out  [7:0] last correctly received byte; held until the next one
//   rx_valid   out  one-cycle pulse; rx_data is new in that cycle
//   frame_err  out  one-cycle pulse; bad stop bit (or bad parity)
//   rx_busy    out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_byte_rx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD_RATE;
   localparam int HALF_CNT     = BAUD_CNT_MAX / 2;
   localparam int CNT_W        = $clog2(BAUD_CNT_MAX);

   // Terminal counts at the compare width of the baud counter.
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_CNT_MAX - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] baud_cnt, baud_next;
   logic [2:0]       bit_cnt, bit_next;
   logic [7:0]       shift_reg, shift_next;
   logic [7:0]       data_next;
   logic             valid_next, ferr_next;
`ifdef UART_RX_PARITY_EN
   logic             par_err, par_next;
`endif

   // Input conditioning: two-flop synchronizer plus one delay stage for edge
   // detection. All three stages reset to 1 so that reset never looks like a
   // start edge.
   logic rx_meta, rx_sync, rx_dly;
   logic fall;

   // NOTE: sequential state uses non-blocking (<=) assignments so every flop
   // samples the values from before the clock edge, whatever the statement
   // order.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_dly  <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_sync <= rx_meta;
         rx_dly  <= rx_sync;
      end
   end

   assign fall = rx_dly & ~rx_sync;

   // State register and datapath registers.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err   <= 1'b0;
`endif
      end else begin
         state     <= state_next;
         baud_cnt  <= baud_next;
         bit_cnt   <= bit_next;
         shift_reg <= shift_next;
         rx_data   <= data_next;
         rx_valid  <= valid_next;
         frame_err <= ferr_next;
`ifdef UART_RX_PARITY_EN
         par_err   <= par_next;
`endif
      end
   end

   // Next-state and datapath logic.
   always_comb begin
      // NOTE: every signal gets a default before the case statement, so no
      // path through the block can leave one unassigned and infer a latch.
      state_next = state;
      baud_next  = baud_cnt;
      bit_next   = bit_cnt;
      shift_next = shift_reg;
      data_next  = rx_data;
      valid_next = 1'b0;
      ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_next   = par_err;
`endif

      case (state)
         IDLE: begin
            baud_next = '0;
            bit_next  = '0;
            // Only a fresh 1->0 transition starts a frame. A line stuck low
            // never does.
            if (fall) state_next = START;
         end

         START: begin
            if (baud_cnt == HALF_LAST) begin
               baud_next = '0;
               // A high line at the start-bit midpoint was a glitch.
               state_next = rx_sync ? IDLE : DATA;
            end else begin
               baud_next = baud_cnt + 1'b1;
            end
         end

         DATA: begin
            if (baud_cnt == BIT_LAST) begin
               baud_next  = '0;
               // LSB arrives first, so shift right and insert at the top.
               shift_next = {rx_sync, shift_reg[7:1]};
               if (bit_cnt == 3'd7) begin
                  bit_next = '0;
`ifdef UART_RX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end else begin
                  bit_next = bit_cnt + 3'd1;
               end
            end else begin
               baud_next = baud_cnt + 1'b1;
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (baud_cnt == BIT_LAST) begin
               baud_next  = '0;
               // Even parity: data bits XOR parity bit must be zero.
               par_next   = ^{shift_reg, rx_sync};
               state_next = STOP;
            end else begin
               baud_next = baud_cnt + 1'b1;
            end
         end
`endif

         STOP: begin
            if (baud_cnt == BIT_LAST) begin
               baud_next  = '0;
               // Going idle at the stop midpoint leaves half a bit to catch
               // the next start edge of a back-to-back frame.
               state_next = IDLE;
`ifdef UART_RX_PARITY_EN
               if (rx_sync && !par_err) begin
`else
               if (rx_sync) begin
`endif
                  data_next  = shift_reg;
                  valid_next = 1'b1;
               end else begin
                  ferr_next = 1'b1;
               end
            end else begin
               baud_next = baud_cnt + 1'b1;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign rx_busy = (state != IDLE);

endmodule
